// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the regfile arbiter: FSM state encoding,
// default bus widths and the round-robin winner search.
package regfile_arb_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;
  localparam int MAX_REQ    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } state_e;

  typedef logic [1:0] idx_t;

  // First set bit of req at or after ptr, wrapping modulo n; 0 if none set.
  function automatic idx_t rr_pick(input logic [MAX_REQ-1:0] req, input idx_t ptr, input int n);
    idx_t idx;
    logic found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = idx_t'((int'(ptr) + i) % n);
      if (i < n && !found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Client-side handshake bundle of the regfile arbiter; master = requesters,
// slave = arbiter.
interface regfile_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ-1:0]        we_i;
  logic [N_REQ*ADDR_W-1:0] addr_i;
  logic [N_REQ*DATA_W-1:0] wdata_i;
  logic [N_REQ-1:0]        ack_o;
  logic [DATA_W-1:0]       rdata_o;
  logic                    clr_req_i;
  logic                    clr_done_o;
  logic                    busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, clr_req_i,
    input  ack_o, rdata_o, clr_done_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, clr_req_i,
    output ack_o, rdata_o, clr_done_o, busy_o
  );
endinterface

// File: rtl/regfile.sv
// 8x4 register file: synchronous write and clear, combinational read.
module regfile #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              load,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // NOTE: storage arrays carry no reset; the explicit clr input is the only way to zero them.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
    end else if (load) begin
      mem_q[addr] <= din;
    end
  end

  assign q = mem_q[addr];
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; the pointer advances past the served
// requester when upd_en pulses.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             upd_en,
  input  idx_t             upd_idx,
  output idx_t             winner,
  output logic             any
);
  idx_t                 ptr_q, ptr_d;
  logic [MAX_REQ-1:0]   req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    winner               = rr_pick(req_ext, ptr_q, N_REQ);
    any                  = |req;
    ptr_d                = ptr_q;
    if (upd_en) begin
      ptr_d = (upd_idx == idx_t'(N_REQ - 1)) ? '0 : upd_idx + idx_t'(1);
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_arbiter.sv
// Shares one regfile between N_REQ requesters: round-robin grant, one access
// per grant (IDLE -> SERVE -> DONE), plus a whole-file clear that beats requests.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_arbiter_if.slave  bus,
  output logic              rf_load_o,
  output logic              rf_clr_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_din_o,
  input  logic [DATA_W-1:0] rf_q_i
);
  state_e            state_q, state_d;
  idx_t              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              clr_done_q, clr_done_d;

  idx_t              pick;
  logic              any_req;
  logic              upd_en;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_i),
    .upd_en  (upd_en),
    .upd_idx (win_q),
    .winner  (pick),
    .any     (any_req)
  );

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    clr_done_d = 1'b0;
    upd_en     = 1'b0;
    bus.ack_o  = '0;
    rf_load_o  = 1'b0;
    rf_clr_o   = 1'b0;
    rf_addr_o  = '0;
    rf_din_o   = '0;

    case (state_q)
      IDLE: begin
        if (bus.clr_req_i) begin
          state_d = CLEAR;
        end else if (any_req) begin
          win_d   = pick;
          // Constant-index mux avoids a variable select wider than the vectors.
          for (int k = 0; k < N_REQ; k++) begin
            if (pick == idx_t'(k)) begin
              we_d    = bus.we_i[k];
              addr_d  = bus.addr_i[k*ADDR_W +: ADDR_W];
              wdata_d = bus.wdata_i[k*DATA_W +: DATA_W];
            end
          end
          state_d = SERVE;
        end
      end
      SERVE: begin
        rf_addr_o = addr_q;
        rf_din_o  = wdata_q;
        rf_load_o = we_q;
        rdata_d   = we_q ? wdata_q : rf_q_i;
        state_d   = DONE;
      end
      DONE: begin
        rf_addr_o = addr_q;
        for (int k = 0; k < N_REQ; k++) begin
          bus.ack_o[k] = (win_q == idx_t'(k));
        end
        upd_en  = 1'b1;
        state_d = IDLE;
      end
      CLEAR: begin
        rf_clr_o   = 1'b1;
        clr_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign bus.rdata_o    = rdata_q;
  assign bus.clr_done_o = clr_done_q;
  assign bus.busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench: arbiter driving a real regfile, acks scored against
// an expectation queue filled as requests are issued.
module tb_regfile_arbiter;
  localparam int N  = 2;
  localparam int AW = 3;
  localparam int DW = 4;

  logic          clk;
  logic          rst_n;
  logic          rf_load, rf_clr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_din, rf_q;

  regfile_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rf_load_o (rf_load),
    .rf_clr_o  (rf_clr),
    .rf_addr_o (rf_addr),
    .rf_din_o  (rf_din),
    .rf_q_i    (rf_q)
  );

  regfile #(.ADDR_W(AW), .DATA_W(DW)) u_rf (
    .clk  (clk),
    .load (rf_load),
    .clr  (rf_clr),
    .addr (rf_addr),
    .din  (rf_din),
    .q    (rf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  ack;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   load_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.ack_o != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(bus.ack_o), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_who", 32'(bus.ack_o), 32'(e.ack));
        check("ack_rdata", 32'(bus.rdata_o), 32'(e.rdata));
      end
    end
    if (rf_load) load_cycles++;
  end

  function automatic exp_t mk(input int k, input int rdata);
    exp_t e;
    e.ack   = N'(1 << k);
    e.rdata = DW'(rdata);
    return e;
  endfunction

  task automatic set_req(input int k, input bit we, input int addr, input int data);
    bus.we_i[k]                 = we;
    bus.addr_i[k*AW +: AW]      = AW'(addr);
    bus.wdata_i[k*DW +: DW]     = DW'(data);
    bus.req_i[k]                = 1'b1;
  endtask

  // Single access by requester k; returns negedges from request to ack.
  task automatic access(input int k, input bit we, input int addr, input int data,
                        input int exp_rdata, output int lat);
    @(negedge clk);
    set_req(k, we, addr, data);
    sb.push_back(mk(k, exp_rdata));
    lat = 0;
    while (!bus.ack_o[k] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.ack_o[k]) check("ack_timeout", 32'd0, 32'd1);
    bus.req_i[k] = 1'b0;
  endtask

  // Count acks up to n within budget cycles; optionally drop each acked req.
  task automatic wait_acks(input int n, input int budget, input bit drop);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.ack_o != '0) begin
        got++;
        if (drop || got == n) bus.req_i = bus.req_i & ~bus.ack_o;
      end
    end
    check("ack_count", 32'(got), 32'(n));
    bus.req_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int l0;
    rst_n         = 1'b0;
    bus.req_i     = '0;
    bus.we_i      = '0;
    bus.addr_i    = '0;
    bus.wdata_i   = '0;
    bus.clr_req_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack",      32'(bus.ack_o), 32'd0);
    check("rst_rdata",    32'(bus.rdata_o), 32'd0);
    check("rst_clr_done", 32'(bus.clr_done_o), 32'd0);
    check("rst_busy",     32'(bus.busy_o), 32'd0);
    check("rst_rf_load",  32'(rf_load), 32'd0);
    check("rst_rf_clr",   32'(rf_clr), 32'd0);
    check("rst_rf_addr",  32'(rf_addr), 32'd0);
    check("rst_rf_din",   32'(rf_din), 32'd0);
    rst_n = 1'b1;

    // Regfile has no reset: clear it so reads have a known starting value.
    @(negedge clk);
    bus.clr_req_i = 1'b1;
    @(negedge clk);
    check("clr_pulse", 32'(rf_clr), 32'd1);
    check("clr_busy",  32'(bus.busy_o), 32'd1);
    bus.clr_req_i = 1'b0;
    @(negedge clk);
    check("clr_done",     32'(bus.clr_done_o), 32'd1);
    check("clr_pulse_end", 32'(rf_clr), 32'd0);

    for (int a = 0; a < 8; a++) begin
      access(0, 1'b0, a, 0, 0, lat);
      check("read_latency", 32'(lat), 32'd2);
    end

    l0 = load_cycles;
    access(1, 1'b1, 5, 'hA, 'hA, lat);
    check("load_one_cycle", 32'(load_cycles - l0), 32'd1);
    access(0, 1'b0, 5, 0, 'hA, lat);

    // Fairness from reset: both hold req, grants must alternate starting at 0.
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 6, 'h3);
    set_req(1, 1'b1, 7, 'hC);
    for (int i = 0; i < 6; i++) sb.push_back(mk(i % 2, (i % 2) ? 'hC : 'h3));
    wait_acks(6, 40, 1'b0);

    for (int a = 0; a < 8; a++) access(a % 2, 1'b1, a, a + 1, a + 1, lat);
    @(negedge clk);
    bus.clr_req_i = 1'b1;
    set_req(0, 1'b0, 3, 0);
    sb.push_back(mk(0, 0));
    @(negedge clk);
    check("clr_first",     32'(rf_clr), 32'd1);
    check("clr_first_ack", 32'(bus.ack_o), 32'd0);
    bus.clr_req_i = 1'b0;
    @(negedge clk);
    check("clr_done2", 32'(bus.clr_done_o), 32'd1);
    check("clr_off2",  32'(rf_clr), 32'd0);
    wait_acks(1, 10, 1'b1);

    // Reset during SERVE of a read: outputs drop at once, no ack, pointer back to 0.
    access(0, 1'b1, 1, 'h9, 'h9, lat);
    @(negedge clk);
    set_req(0, 1'b0, 1, 0);
    @(posedge clk);
    #1;
    check("serve_addr", 32'(rf_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  32'(bus.busy_o), 32'd0);
    check("midrst_rdata", 32'(bus.rdata_o), 32'd0);
    check("midrst_addr",  32'(rf_addr), 32'd0);
    check("midrst_ack",   32'(bus.ack_o), 32'd0);
    bus.req_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 1'b0, 1, 0);
    set_req(1, 1'b0, 0, 0);
    sb.push_back(mk(0, 'h9));
    sb.push_back(mk(1, 'h0));
    wait_acks(2, 20, 1'b1);

    // Requester withdraws during SERVE: the write still lands and acks.
    @(negedge clk);
    set_req(0, 1'b1, 2, 'h7);
    sb.push_back(mk(0, 'h7));
    @(negedge clk);
    bus.req_i[0] = 1'b0;
    wait_acks(1, 10, 1'b1);
    access(1, 1'b0, 2, 0, 'h7, lat);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
